// File: rtl/d2s_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : d2s_scheduler_if
// Brief    : Requester/display bundle between requesters and d2s_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface d2s_scheduler_if #(
  parameter int NReq = 4
);
  logic [NReq-1:0]   Req;
  logic [4*NReq-1:0] ReqData;
  logic [NReq-1:0]   ReqY;
  logic [8*NReq-1:0] ReqLiteral;
  logic [NReq-1:0]   Ack;
  logic [NReq-1:0]   Grant;
  logic              Busy;
  logic [3:0]        data;
  logic              y;
  logic [7:0]        st_literal;

  modport master (
    output Req, ReqData, ReqY, ReqLiteral,
    input  Ack, Grant, Busy, data, y, st_literal
  );

  modport slave (
    input  Req, ReqData, ReqY, ReqLiteral,
    output Ack, Grant, Busy, data, y, st_literal
  );
endinterface
`default_nettype wire

// File: rtl/d2s_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : d2s_scheduler
// Brief    : Time-shares one 7-segment display driver between NReq requesters,
//            round-robin, holding each granted frame for a minimum dwell.
//            Define D2S_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module d2s_scheduler #(
  parameter int NReq           = 4,
  parameter int ClockPeriod_ns = 20,
  parameter int HoldTime_ns    = 500_000_000
) (
  input  wire logic      Clock,
  input  wire logic      Reset,
  d2s_scheduler_if.slave bus
);
  localparam int HoldCycles   = HoldTime_ns / ClockPeriod_ns;
  localparam int HCounterSize = $clog2(HoldCycles + 1);
  localparam int PtrW         = $clog2(NReq);

  generate
    if (HoldCycles < 1) begin : g_bad_hold
      $error("d2s_scheduler: HoldCycles must be >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                  r_state, w_state_n;
  logic [HCounterSize-1:0] r_cnt,   w_cnt_n;
  logic [PtrW-1:0]         r_ptr,   w_ptr_n;
  logic [NReq-1:0]         r_ack,   w_ack_n;
  logic [NReq-1:0]         r_grant, w_grant_n;
  logic                    r_busy,  w_busy_n;
  logic [3:0]              r_data,  w_data_n;
  logic                    r_y,     w_y_n;
  logic [7:0]              r_lit,   w_lit_n;

  logic [NReq-1:0]         w_req_m;
  logic [NReq-1:0]         w_onehot;
  logic                    w_found;
  logic [PtrW-1:0]         w_win;
  logic [PtrW-1:0]         w_idx;

  // A requester whose Ack is high this cycle is masked so it cannot be re-granted
  // for the same request when the dwell is a single cycle.
  always_comb begin
    w_req_m = bus.Req & ~r_ack;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NReq; k++) begin
`ifdef D2S_SCHED_FIXED_PRIO_EN
      w_idx = PtrW'(k);
`else
      w_idx = (int'(r_ptr) + k >= NReq) ? PtrW'(int'(r_ptr) + k - NReq)
                                        : PtrW'(int'(r_ptr) + k);
`endif
      if (!w_found && w_req_m[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ptr_n   = r_ptr;
    w_ack_n   = '0;
    w_grant_n = r_grant;
    w_busy_n  = r_busy;
    w_data_n  = r_data;
    w_y_n     = r_y;
    w_lit_n   = r_lit;
    if (r_state == S_HOLD && r_cnt != '0) begin
      w_cnt_n = r_cnt - 1'b1;
    end else if (w_found) begin
      w_data_n  = bus.ReqData[4*int'(w_win) +: 4];
      w_y_n     = bus.ReqY[w_win];
      w_lit_n   = bus.ReqLiteral[8*int'(w_win) +: 8];
      w_grant_n = w_onehot;
      w_ack_n   = w_onehot;
      w_busy_n  = 1'b1;
      w_cnt_n   = HCounterSize'(HoldCycles - 1);
`ifndef D2S_SCHED_FIXED_PRIO_EN
      w_ptr_n   = (w_win == PtrW'(NReq - 1)) ? '0 : w_win + 1'b1;
`endif
      w_state_n = S_HOLD;
    end else begin
      // Frame outputs are left alone: the display keeps the last frame.
      w_grant_n = '0;
      w_busy_n  = 1'b0;
      w_state_n = S_IDLE;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_data  <= 4'h0;
      r_y     <= 1'b0;
      r_lit   <= 8'hFF;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_ack   <= w_ack_n;
      r_grant <= w_grant_n;
      r_busy  <= w_busy_n;
      r_data  <= w_data_n;
      r_y     <= w_y_n;
      r_lit   <= w_lit_n;
    end
  end

  assign bus.Ack        = r_ack;
  assign bus.Grant      = r_grant;
  assign bus.Busy       = r_busy;
  assign bus.data       = r_data;
  assign bus.y          = r_y;
  assign bus.st_literal = r_lit;
endmodule
`default_nettype wire
